// File: rtl/codificador_prioridad_hs.sv
// -----------------------------------------------------------------------------
// codificador_prioridad_hs
//
// Parametrised priority encoder with a registered valid/ready output stage.
// Encodes an N-bit request vector X into a 1-based index (0 = no request) and
// holds the result until the consumer takes it. It is a 1-deep pipeline with
// full throughput: a new X can be accepted on the same edge that the held
// result is consumed.
//
// Parameters:
//   N    number of request inputs (N >= 2)
//   ALTA 1 = highest set index wins, 0 = lowest set index wins
//   W    output code width, derived as $clog2(N+1)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   X          request vector, bit i encodes as i+1
//   in_valid   X is valid this cycle
//   in_ready   block can accept X this cycle (combinational from out_ready)
//   Salida     encoded index, stable while out_valid && !out_ready
//   out_valid  Salida holds an unconsumed result
//   out_ready  consumer accepts Salida this cycle
//   vacio      captured X was all zeros, qualified by out_valid
//   err        captured X had more than one bit set, qualified by out_valid
//              (present only when CODIFICADOR_MULTIHOT_ERR_EN is defined)
//
// Optional build macro: CODIFICADOR_MULTIHOT_ERR_EN adds the err port and the
// multi-hot detector. Priority resolution is identical either way.
// -----------------------------------------------------------------------------
module codificador_prioridad_hs #(
    parameter int unsigned  N    = 7,
    parameter int unsigned  ALTA = 1,
    localparam int unsigned W    = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] X,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] Salida,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         vacio
`ifdef CODIFICADOR_MULTIHOT_ERR_EN
    ,
    output logic         err
`endif
);

    localparam logic ST_VACIO = 1'b0;
    localparam logic ST_LLENO = 1'b1;

    logic         state_q, state_d;
    logic [W-1:0] salida_q;
    logic         vacio_q;
    logic [W-1:0] code;
    logic         accept;
    logic         consume;

    // Priority encode: the loop direction decides which set bit is seen last
    // and therefore wins.
    always_comb begin
        code = '0;
        if (ALTA != 0) begin
            for (int i = 0; i < int'(N); i++) begin
                if (X[i]) code = W'(i + 1);
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (X[i]) code = W'(i + 1);
            end
        end
    end

    // A consumer stalling only blocks input while a result is held.
    assign in_ready = (state_q == ST_VACIO) || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = (state_q == ST_LLENO) && out_ready;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_LLENO;
        end else if (consume) begin
            state_d = ST_VACIO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_VACIO;
            salida_q <= '0;
            vacio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                salida_q <= code;
                vacio_q  <= (X == '0);
            end
        end
    end

    assign Salida    = salida_q;
    assign out_valid = (state_q == ST_LLENO);
    assign vacio     = vacio_q;

`ifdef CODIFICADOR_MULTIHOT_ERR_EN
    logic multi;
    logic err_q;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(X & (X - {{(N-1){1'b0}}, 1'b1}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= multi;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_codificador_prioridad_hs.sv
module tb_codificador_prioridad_hs;

    logic       clk;
    logic       rst_n;
    logic [6:0] x7;
    logic [7:0] x8;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_h, ov_h, vacio_h;
    logic [2:0] salida_h;
    logic       in_ready_l, ov_l, vacio_l;
    logic [2:0] salida_l;
    logic       in_ready_8, ov_8, vacio_8;
    logic [3:0] salida_8;
`ifdef CODIFICADOR_MULTIHOT_ERR_EN
    logic       err_h, err_l, err_8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    codificador_prioridad_hs #(.N(7), .ALTA(1)) dut_alta (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (x7),
        .in_valid  (in_valid),
        .in_ready  (in_ready_h),
        .Salida    (salida_h),
        .out_valid (ov_h),
        .out_ready (out_ready),
        .vacio     (vacio_h)
`ifdef CODIFICADOR_MULTIHOT_ERR_EN
        ,
        .err       (err_h)
`endif
    );

    codificador_prioridad_hs #(.N(7), .ALTA(0)) dut_baja (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (x7),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .Salida    (salida_l),
        .out_valid (ov_l),
        .out_ready (out_ready),
        .vacio     (vacio_l)
`ifdef CODIFICADOR_MULTIHOT_ERR_EN
        ,
        .err       (err_l)
`endif
    );

    codificador_prioridad_hs #(.N(8), .ALTA(1)) dut_ocho (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (x8),
        .in_valid  (in_valid),
        .in_ready  (in_ready_8),
        .Salida    (salida_8),
        .out_valid (ov_8),
        .out_ready (out_ready),
        .vacio     (vacio_8)
`ifdef CODIFICADOR_MULTIHOT_ERR_EN
        ,
        .err       (err_8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] x;
        logic       iv;
        logic       ordy;
        logic       exp_inr;  // in_ready before the edge
        logic       exp_ov;   // out_valid after the edge
        logic [2:0] exp_sh;   // Salida, ALTA=1
        logic [2:0] exp_sl;   // Salida, ALTA=0
        logic       exp_vacio;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [6:0] x, input logic iv, input logic ordy,
                                input logic inr, input logic ov, input logic [2:0] sh,
                                input logic [2:0] sl, input logic vac, input logic er);
        vec_t v;
        v.x = x; v.iv = iv; v.ordy = ordy; v.exp_inr = inr; v.exp_ov = ov;
        v.exp_sh = sh; v.exp_sl = sl; v.exp_vacio = vac; v.exp_err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        x7        = v.x;
        in_valid  = v.iv;
        out_ready = v.ordy;
        #1;
        check($sformatf("v%0d in_ready alta", idx), 32'(in_ready_h), 32'(v.exp_inr));
        check($sformatf("v%0d in_ready baja", idx), 32'(in_ready_l), 32'(v.exp_inr));
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid alta", idx), 32'(ov_h), 32'(v.exp_ov));
        check($sformatf("v%0d out_valid baja", idx), 32'(ov_l), 32'(v.exp_ov));
        if (v.exp_ov) begin
            check($sformatf("v%0d Salida alta", idx), 32'(salida_h), 32'(v.exp_sh));
            check($sformatf("v%0d Salida baja", idx), 32'(salida_l), 32'(v.exp_sl));
            check($sformatf("v%0d vacio", idx), 32'(vacio_h), 32'(v.exp_vacio));
`ifdef CODIFICADOR_MULTIHOT_ERR_EN
            check($sformatf("v%0d err alta", idx), 32'(err_h), 32'(v.exp_err));
            check($sformatf("v%0d err baja", idx), 32'(err_l), 32'(v.exp_err));
`endif
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        x7        = '0;
        x8        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        //            x           iv  rdy inr ov  sh  sl  vac err
        // One-hot sweep with a consumer that never stalls.
        vecs.push_back(mk(7'b0000001, 1, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(7'b0000010, 1, 1, 1, 1, 2, 2, 0, 0));
        vecs.push_back(mk(7'b0000100, 1, 1, 1, 1, 3, 3, 0, 0));
        vecs.push_back(mk(7'b0001000, 1, 1, 1, 1, 4, 4, 0, 0));
        vecs.push_back(mk(7'b0010000, 1, 1, 1, 1, 5, 5, 0, 0));
        vecs.push_back(mk(7'b0100000, 1, 1, 1, 1, 6, 6, 0, 0));
        vecs.push_back(mk(7'b1000000, 1, 1, 1, 1, 7, 7, 0, 0));
        // Multi-hot priority, then single-hot, then zero.
        vecs.push_back(mk(7'b0100101, 1, 1, 1, 1, 6, 1, 0, 1));
        vecs.push_back(mk(7'b0010000, 1, 1, 1, 1, 5, 5, 0, 0));
        vecs.push_back(mk(7'b0000000, 1, 1, 1, 1, 0, 0, 1, 0));
        // Drain, then idle with in_valid low: X must be ignored.
        vecs.push_back(mk(7'b1111111, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(7'b1111111, 0, 0, 1, 0, 0, 0, 0, 0));
        // Backpressure: hold 4 for five stalled cycles while X changes.
        vecs.push_back(mk(7'b0001000, 1, 0, 1, 1, 4, 4, 0, 0));
        vecs.push_back(mk(7'b1111111, 1, 0, 0, 1, 4, 4, 0, 0));
        vecs.push_back(mk(7'b0000001, 1, 0, 0, 1, 4, 4, 0, 0));
        vecs.push_back(mk(7'b1010101, 1, 0, 0, 1, 4, 4, 0, 0));
        vecs.push_back(mk(7'b0000000, 1, 0, 0, 1, 4, 4, 0, 0));
        vecs.push_back(mk(7'b1000000, 1, 0, 0, 1, 4, 4, 0, 0));
        // Consume 4 and load 2 on the same edge: no bubble.
        vecs.push_back(mk(7'b0000010, 1, 1, 1, 1, 2, 2, 0, 0));
        vecs.push_back(mk(7'b0000000, 0, 1, 1, 0, 0, 0, 0, 0));

        // Reset state while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(ov_h), 32'd0);
        check("reset Salida", 32'(salida_h), 32'd0);
        check("reset vacio", 32'(vacio_h), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 32'(in_ready_h), 32'd1);

        foreach (vecs[i]) apply(vecs[i], i);

        // Width: N=8 code for bit 7 needs the 4th output bit.
        x7        = '0;
        x8        = 8'b10000000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("n8 out_valid", 32'(ov_8), 32'd1);
        check("n8 Salida bit7", 32'(salida_8), 32'd8);
        check("n8 vacio", 32'(vacio_8), 32'd0);
`ifdef CODIFICADOR_MULTIHOT_ERR_EN
        check("n8 err onehot", 32'(err_8), 32'd0);
`endif
        x8 = 8'b01000001;
        #1;
        check("n8 in_ready", 32'(in_ready_8), 32'd1);
        @(posedge clk);
        #1;
        check("n8 Salida multi", 32'(salida_8), 32'd7);
`ifdef CODIFICADOR_MULTIHOT_ERR_EN
        check("n8 err multi", 32'(err_8), 32'd1);
`endif
        x8       = '0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-transfer: held result is dropped asynchronously.
        x7        = 7'b0000100;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("prereset out_valid", 32'(ov_h), 32'd1);
        check("prereset Salida", 32'(salida_h), 32'd3);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(ov_h), 32'd0);
        check("async reset Salida", 32'(salida_h), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post reset in_ready", 32'(in_ready_h), 32'd1);
        @(posedge clk);
        #1;
        check("post reset out_valid", 32'(ov_h), 32'd0);
        check("post reset in_ready edge", 32'(in_ready_h), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
